// File: rtl/scr1_dmem_responder_pkg.sv
// Shared DMEM interface types and the responder FSM encoding.
// Widths and enum encodings follow the SCR1 memif header.
package scr1_dmem_responder_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    SCR1_DMEM_FSM_IDLE = 2'b00,
    SCR1_DMEM_FSM_WAIT = 2'b01,
    SCR1_DMEM_FSM_RESP = 2'b10
  } type_scr1_dmem_resp_fsm_e;

  function automatic logic width_legal(
    input type_scr1_mem_width_e w
  );
    return (w == SCR1_MEM_WIDTH_BYTE)
        || (w == SCR1_MEM_WIDTH_HWORD)
        || (w == SCR1_MEM_WIDTH_WORD);
  endfunction

endpackage

// File: rtl/scr1_dmem_lane_align.sv
// Byte-lane placement for stores and LSB alignment for loads.
// Purely combinational; also flags misaligned accesses.
module scr1_dmem_lane_align
  import scr1_dmem_responder_pkg::*;
(
  input  type_scr1_mem_width_e  width,
  input  logic [1:0]            offset,
  input  logic [31:0]           wdata,
  input  logic [31:0]           rdword,
  output logic [3:0]            be,
  output logic [31:0]           wdata_sh,
  output logic [31:0]           rdata,
  output logic                  misalign
);

  logic [3:0]  be_base;
  logic [31:0] rmask;
  logic [31:0] rsh;
  logic [4:0]  bit_sh;

  assign bit_sh = {offset, 3'b000};

  always_comb begin
    be_base  = 4'b0000;
    rmask    = 32'h0;
    misalign = 1'b0;
    case (width)
      SCR1_MEM_WIDTH_BYTE: begin
        be_base = 4'b0001;
        rmask   = 32'h0000_00ff;
      end
      SCR1_MEM_WIDTH_HWORD: begin
        be_base  = 4'b0011;
        rmask    = 32'h0000_ffff;
        misalign = offset[0];
      end
      SCR1_MEM_WIDTH_WORD: begin
        be_base  = 4'b1111;
        rmask    = 32'hffff_ffff;
        misalign = |offset;
      end
      default: begin
        be_base  = 4'b0000;
        rmask    = 32'h0;
        misalign = 1'b0;
      end
    endcase
  end

  assign be       = be_base << offset;
  assign wdata_sh = wdata << bit_sh;
  assign rsh      = rdword >> bit_sh;
  assign rdata    = rsh & rmask;

endmodule

// File: rtl/scr1_dmem_responder.sv
// Single-outstanding DMEM target: tightly-coupled RAM with
// programmable wait states and OK/ER response.
module scr1_dmem_responder
  import scr1_dmem_responder_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dmem_req_i,
  input  type_scr1_mem_cmd_e          dmem_cmd_i,
  input  type_scr1_mem_width_e        dmem_width_i,
  input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata_i,
  output logic                        dmem_req_ack_o,
  output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata_o,
  output type_scr1_mem_resp_e         dmem_resp_o
);

  localparam int          IDXW  = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);
  localparam int          WS_M1 =
    (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [2:0]  CNT_LD = 3'(WS_M1);

  type_scr1_dmem_resp_fsm_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  type_scr1_mem_cmd_e   cmd_q;
  type_scr1_mem_width_e width_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;

  logic accept;
  logic [31:0] rel;
  logic [IDXW-1:0] idx;
  logic oor;
  logic misalign;
  logic err;
  logic in_resp;
  logic we;

  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic [31:0] rdata_al;

  logic [31:0] mem [DEPTH];

  assign dmem_req_ack_o = (state_q == SCR1_DMEM_FSM_IDLE) & ~rst;
  assign accept         = dmem_req_i & dmem_req_ack_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCR1_DMEM_FSM_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SCR1_DMEM_FSM_IDLE: begin
        if (accept) begin
          cnt_d   = CNT_LD;
          state_d = (WAIT_STATES > 0) ? SCR1_DMEM_FSM_WAIT
                                      : SCR1_DMEM_FSM_RESP;
        end
      end
      SCR1_DMEM_FSM_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = SCR1_DMEM_FSM_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      SCR1_DMEM_FSM_RESP: begin
        state_d = SCR1_DMEM_FSM_IDLE;
      end
      default: begin
        state_d = SCR1_DMEM_FSM_IDLE;
      end
    endcase
  end

  // Request capture; fields are frozen until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q   <= SCR1_MEM_CMD_RD;
      width_q <= SCR1_MEM_WIDTH_BYTE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      cmd_q   <= dmem_cmd_i;
      width_q <= dmem_width_i;
      addr_q  <= dmem_addr_i;
      wdata_q <= dmem_wdata_i;
    end
  end

  assign rel = addr_q - BASE_ADDR;
  assign oor = (rel >= SPAN);
  assign idx = rel[IDXW+1:2];
  assign err = oor | misalign | ~width_legal(width_q);

  scr1_dmem_lane_align u_align (
    .width    (width_q),
    .offset   (addr_q[1:0]),
    .wdata    (wdata_q),
    .rdword   (mem[idx]),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (rdata_al),
    .misalign (misalign)
  );

  assign in_resp = (state_q == SCR1_DMEM_FSM_RESP);
  assign we = in_resp & ~rst & ~err
            & (cmd_q == SCR1_MEM_CMD_WR);

  // Array is deliberately unreset so contents survive rst.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_comb begin
    dmem_resp_o  = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata_o = '0;
    if (in_resp) begin
      dmem_resp_o = err ? SCR1_MEM_RESP_RDY_ER
                        : SCR1_MEM_RESP_RDY_OK;
      if (!err && cmd_q == SCR1_MEM_CMD_RD) begin
        dmem_rdata_o = rdata_al;
      end
    end
  end

endmodule
